// File: rtl/switch_irq_servicer.sv
// -----------------------------------------------------------------------------
// switch_irq_servicer
//
// Avalon-MM host that services an 8-bit edge-capturing switch PIO on its s1
// slave port without CPU involvement. It is the only host on that slave.
//   * After reset it programs the PIO irq mask with INIT_MASK. Later mask
//     changes arrive through mask_cfg/mask_load.
//   * On irq it reads the edge-capture register, writes back exactly the bits
//     it read (write-1-to-clear), then reads the live switch levels.
//   * Each serviced interrupt becomes one record on a valid/ready stream.
//
// Event stream handshake: evt_valid rises with a complete record. evt_edges,
// evt_level and evt_seq then stay frozen until the cycle in which evt_valid
// and evt_ready are both high. That rising clock edge is the transfer. A
// consumer may hold evt_ready high before evt_valid appears.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   address[1:0]      PIO register select (0 data, 2 irq mask, 3 edge capture)
//   chipselect        one-cycle access strobe
//   write_n           active-low write qualifier
//   writedata[31:0]   write data, bits 31:8 always zero
//   readdata[31:0]    PIO read data (fixed latency 1, bits 7:0 used)
//   irq               PIO interrupt level
//   mask_cfg[7:0]     new irq mask value
//   mask_load         one-cycle request to write mask_cfg to the PIO
//   evt_valid/ready   event record handshake
//   evt_edges[7:0]    edge-capture bits serviced by this record
//   evt_level[7:0]    switch levels read after the clear
//   evt_seq[7:0]      record sequence number, wraps 255 -> 0
//   spurious_cnt[7:0] interrupts that showed no captured edge, saturating
//   state_dbg[2:0]    current FSM state, for observation only
// -----------------------------------------------------------------------------
module switch_irq_servicer #(
  parameter logic [7:0] INIT_MASK = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  output logic [1:0]  address,
  output logic        chipselect,
  output logic        write_n,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        irq,
  input  logic [7:0]  mask_cfg,
  input  logic        mask_load,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [7:0]  evt_edges,
  output logic [7:0]  evt_level,
  output logic [7:0]  evt_seq,
  output logic [7:0]  spurious_cnt,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    WR_MASK   = 3'd0,
    IDLE      = 3'd1,
    RD_CAP    = 3'd2,
    CAP_WAIT  = 3'd3,
    CLR       = 3'd4,
    RD_DATA   = 3'd5,
    DATA_WAIT = 3'd6,
    EMIT      = 3'd7
  } state_t;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_CAP  = 2'd3;

  state_t     state;
  state_t     state_nxt;

  logic       mask_pend;
  logic [7:0] mask_val;

  // Raw bus request decoded from the state, before reset gating.
  logic       bus_cs;
  logic       bus_wr;
  logic [1:0] bus_addr;
  logic [31:0] bus_wd;

  logic [7:0] rd_byte;
  logic       rd_zero;

  // Only the low byte of the PIO read data carries information.
  logic       unused_readdata_hi;
  assign unused_readdata_hi = ^readdata[31:8];

  assign rd_byte = readdata[7:0];
  assign rd_zero = (rd_byte == 8'h00);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= WR_MASK;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      WR_MASK:   state_nxt = IDLE;
      IDLE: begin
        // A pending mask update wins over irq. The mask write is a single
        // cycle, so the interrupt is still seen on the next IDLE visit.
        if (mask_pend) begin
          state_nxt = WR_MASK;
        end else if (irq) begin
          state_nxt = RD_CAP;
        end
      end
      RD_CAP:    state_nxt = CAP_WAIT;
      // With latency 1, readdata for the RD_CAP read is valid during this
      // cycle.
      CAP_WAIT:  state_nxt = rd_zero ? IDLE : CLR;
      CLR:       state_nxt = RD_DATA;
      RD_DATA:   state_nxt = DATA_WAIT;
      DATA_WAIT: state_nxt = EMIT;
      EMIT: begin
        if (evt_ready) begin
          state_nxt = IDLE;
        end
      end
      default:   state_nxt = WR_MASK;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bus request decode. Exactly one access in each of WR_MASK, RD_CAP, CLR
  // and RD_DATA. Every other state, including EMIT while it stalls, leaves
  // the bus idle.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus_cs   = 1'b0;
    bus_wr   = 1'b0;
    bus_addr = ADDR_DATA;
    bus_wd   = 32'd0;
    case (state)
      WR_MASK: begin
        bus_cs   = 1'b1;
        bus_wr   = 1'b1;
        bus_addr = ADDR_MASK;
        bus_wd   = {24'd0, mask_val};
      end
      RD_CAP: begin
        bus_cs   = 1'b1;
        bus_addr = ADDR_CAP;
      end
      CLR: begin
        // Clear only the bits that were read. Edges captured after the read
        // stay set in the PIO and keep irq asserted for the next pass.
        bus_cs   = 1'b1;
        bus_wr   = 1'b1;
        bus_addr = ADDR_CAP;
        bus_wd   = {24'd0, evt_edges};
      end
      RD_DATA: begin
        bus_cs   = 1'b1;
        bus_addr = ADDR_DATA;
      end
      default: begin
        bus_cs   = 1'b0;
      end
    endcase
  end

  // The state register resets to WR_MASK. Gating with reset keeps the bus
  // idle while reset is held, so the mask write lands in the first cycle
  // after release.
  always_comb begin
    chipselect = bus_cs & ~reset;
    write_n    = ~(bus_wr & ~reset);
    address    = reset ? ADDR_DATA : bus_addr;
    writedata  = reset ? 32'd0 : bus_wd;
  end

  // ---------------------------------------------------------------------------
  // Mask request latch. The last mask_load pulse wins. A pulse that lands in
  // the WR_MASK cycle re-arms the request with the new value. In that case
  // the write going out this cycle still carries the previous mask_val.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_pend <= 1'b0;
      mask_val  <= INIT_MASK;
    end else begin
      if (mask_load) begin
        mask_pend <= 1'b1;
        mask_val  <= mask_cfg;
      end else if (state == WR_MASK) begin
        mask_pend <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Event record and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_edges    <= 8'h00;
      evt_level    <= 8'h00;
      evt_seq      <= 8'h00;
      spurious_cnt <= 8'h00;
    end else begin
      if (state == CAP_WAIT) begin
        if (rd_zero) begin
          if (spurious_cnt != 8'hFF) begin
            spurious_cnt <= spurious_cnt + 8'd1;
          end
        end else begin
          evt_edges <= rd_byte;
        end
      end
      if (state == DATA_WAIT) begin
        evt_level <= rd_byte;
      end
      if ((state == EMIT) && evt_ready) begin
        evt_seq <= evt_seq + 8'd1;
      end
    end
  end

  assign evt_valid = (state == EMIT);
  assign state_dbg = state;

endmodule

// File: tb/tb_switch_irq_servicer.sv
// -----------------------------------------------------------------------------
// tb_switch_irq_servicer
//
// Testbench for switch_irq_servicer.
//
// The bench contains a behavioural model of the switch PIO slave. The model
// provides edge capture, the irq mask and write-1-to-clear, and returns read
// data one cycle after the access. Every bus access is logged.
//
// The reference model tracks which switches have changed since they were last
// serviced (m_pend). When the bench knows a service pass will run, it pushes
// the expected record {edges, level, seq} onto exp_q. A monitor compares every
// presented record with the head of exp_q and pops it on the handshake.
// -----------------------------------------------------------------------------
module tb_switch_irq_servicer;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [7:0]  mask_cfg;
  logic        mask_load;
  logic        evt_valid;
  logic        evt_ready;
  logic [7:0]  evt_edges;
  logic [7:0]  evt_level;
  logic [7:0]  evt_seq;
  logic [7:0]  spurious_cnt;
  logic [2:0]  state_dbg;

  switch_irq_servicer #(.INIT_MASK(8'hFF)) dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .chipselect   (chipselect),
    .write_n      (write_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .irq          (irq),
    .mask_cfg     (mask_cfg),
    .mask_load    (mask_load),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_edges    (evt_edges),
    .evt_level    (evt_level),
    .evt_seq      (evt_seq),
    .spurious_cnt (spurious_cnt),
    .state_dbg    (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // PIO slave model with bus log
  // ---------------------------------------------------------------------------
  logic [7:0]  sw;
  logic        fake_irq;
  logic        force_zero;
  logic [7:0]  in_prev  = 8'h00;
  logic [7:0]  cap      = 8'h00;
  logic [7:0]  pio_mask = 8'h00;
  logic [31:0] rd_reg   = 32'd0;
  int          cyc          = 0;
  int          last_acc_cyc = 0;
  int          rd3_cnt      = 0;
  logic [34:0] bus_q[$];      // {is_write, address, writedata}
  int          bus_cyc_q[$];

  assign readdata = force_zero ? 32'd0 : rd_reg;
  assign irq      = (|(cap & pio_mask)) | fake_irq;

  always @(posedge clk) begin
    logic [7:0] clr;
    clr = 8'h00;
    cyc = cyc + 1;
    if (chipselect) begin
      bus_q.push_back({~write_n, address, writedata});
      bus_cyc_q.push_back(cyc);
      last_acc_cyc = cyc;
      if (write_n) begin
        if (address == 2'd3) rd3_cnt = rd3_cnt + 1;
        case (address)
          2'd0:    rd_reg <= {24'd0, sw};
          2'd2:    rd_reg <= {24'd0, pio_mask};
          2'd3:    rd_reg <= {24'd0, cap};
          default: rd_reg <= 32'd0;
        endcase
      end else begin
        if (address == 2'd2) pio_mask <= writedata[7:0];
        if (address == 2'd3) clr = writedata[7:0];
      end
    end
    cap     <= (cap & ~clr) | (sw ^ in_prev);
    in_prev <= sw;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  logic [23:0] exp_q[$];      // {edges, level, seq}
  logic [7:0]  m_pend;
  logic [7:0]  m_mask;
  logic [7:0]  m_seq;
  int          checks;
  int          errors;
  int          ready_mode;    // 0 hold low, 1 hold high, 2 random
  int          hs_cyc;
  int          irq_rise;
  int          vld_rise;
  logic        prev_irq;
  logic        prev_vld;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic toggle(input logic [7:0] b);
    sw     = sw ^ b;
    m_pend = m_pend | b;
  endtask

  task automatic push_evt(input logic [7:0] e);
    exp_q.push_back({e, sw, m_seq});
    m_seq = m_seq + 8'd1;
  endtask

  // An interrupt is raised only by captured bits that the mask enables.
  // Servicing it reports every captured bit, then the capture is empty.
  task automatic service();
    if ((m_pend & m_mask) != 8'h00) begin
      push_evt(m_pend);
      m_pend = 8'h00;
    end
  endtask

  function automatic bit is_quiet();
    return (exp_q.size() == 0) && !evt_valid && !irq && ((cyc - last_acc_cyc) >= 10);
  endfunction

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!is_quiet() && n < budget);
    check("settle", 64'(is_quiet()), 64'd1);
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!evt_valid && n < budget);
    check("wait_valid", 64'(evt_valid), 64'd1);
  endtask

  task automatic wait_access(input logic wr, input logic [1:0] a, input int budget);
    int n;
    bit hit;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      hit = chipselect && (write_n == !wr) && (address == a);
    end while (!hit && n < budget);
    check("wait_access", 64'(hit), 64'd1);
  endtask

  task automatic pulse_mask(input logic [7:0] v);
    mask_cfg  = v;
    mask_load = 1'b1;
    @(negedge clk);
    mask_load = 1'b0;
  endtask

  function automatic int count_writes(input int base);
    int w;
    w = 0;
    for (int i = base; i < bus_q.size(); i++) begin
      if (bus_q[i][34]) w++;
    end
    return w;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bus"}, 64'({chipselect, write_n, address, writedata}), 64'({1'b0, 1'b1, 2'd0, 32'd0}));
    check({tag, "_evt_valid"}, 64'(evt_valid), 64'd0);
    check({tag, "_record"}, 64'({evt_edges, evt_level, evt_seq}), 64'd0);
    check({tag, "_spurious"}, 64'(spurious_cnt), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int base;
    int base_cyc;
    int rd3_base;
    int n_spur;
    logic [7:0] e;

    reset      = 1'b1;
    sw         = 8'h00;
    mask_cfg   = 8'h00;
    mask_load  = 1'b0;
    evt_ready  = 1'b0;
    fake_irq   = 1'b0;
    force_zero = 1'b0;
    m_pend     = 8'h00;
    m_mask     = 8'hFF;
    m_seq      = 8'h00;
    checks     = 0;
    errors     = 0;
    ready_mode = 0;
    hs_cyc     = 0;
    irq_rise   = 0;
    vld_rise   = 0;
    prev_irq   = 1'b0;
    prev_vld   = 1'b0;

    fork
      // Ready driver
      forever begin
        @(negedge clk);
        if (ready_mode == 1)      evt_ready = 1'b1;
        else if (ready_mode == 2) evt_ready = 1'($urandom_range(0, 1));
        else                      evt_ready = 1'b0;
      end
      // Monitor: compares each presented record, pops on handshake
      forever begin
        @(negedge clk);
        #1;
        if (irq && !prev_irq) irq_rise = cyc;
        if (evt_valid && !prev_vld) vld_rise = cyc;
        prev_irq = irq;
        prev_vld = evt_valid;
        if (!reset && evt_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got %h expected none", {evt_edges, evt_level, evt_seq});
          end else begin
            check("evt_record", 64'({evt_edges, evt_level, evt_seq}), 64'(exp_q[0]));
            if (evt_ready) begin
              void'(exp_q.pop_front());
              hs_cyc = cyc + 1;
            end
          end
        end
      end
      // Watchdog
      begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    // --- Reset state and init mask write -------------------------------------
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    base     = bus_q.size();
    base_cyc = cyc;
    reset    = 1'b0;
    repeat (12) @(negedge clk);
    check("init_access_count", 64'(bus_q.size() - base), 64'd1);
    if (bus_q.size() > base) begin
      check("init_mask_write", 64'(bus_q[base]), 64'({1'b1, 2'd2, 32'h000000FF}));
      check("init_mask_cycle", 64'(bus_cyc_q[base] - base_cyc), 64'd1);
    end

    // --- Single toggle: switch 3 ---------------------------------------------
    ready_mode = 1;
    @(negedge clk);
    base = bus_q.size();
    toggle(8'h08);
    service();
    wait_quiet(100);
    check("t2_access_count", 64'(bus_q.size() - base), 64'd3);
    if (bus_q.size() >= base + 3) begin
      check("t2_rd_cap",  64'(bus_q[base]),     64'({1'b0, 2'd3, 32'd0}));
      check("t2_clr",     64'(bus_q[base + 1]), 64'({1'b1, 2'd3, 32'h08}));
      check("t2_rd_data", 64'(bus_q[base + 2]), 64'({1'b0, 2'd0, 32'd0}));
    end
    check("t2_latency", 64'(vld_rise - irq_rise), 64'd6);

    // --- Backpressure: switch 2 event stalls, switch 5 toggles meanwhile -----
    ready_mode = 0;
    repeat (2) @(negedge clk);
    toggle(8'h04);
    service();
    wait_valid(50);
    base = bus_q.size();
    toggle(8'h20);
    repeat (20) @(negedge clk);
    check("stall_no_bus", 64'(bus_q.size() - base), 64'd0);
    check("stall_valid_held", 64'(evt_valid), 64'd1);
    ready_mode = 1;
    service();
    wait_quiet(100);

    // --- Switch 0, then switch 1 toggled during CLR --------------------------
    toggle(8'h01);
    wait_access(1'b1, 2'd3, 50);
    check("clr_data", 64'(writedata), 64'h01);
    e      = m_pend;
    m_pend = 8'h00;
    toggle(8'h02);
    push_evt(e);
    service();
    wait_quiet(100);

    // --- mask_load during EMIT -----------------------------------------------
    ready_mode = 0;
    repeat (2) @(negedge clk);
    toggle(8'h40);
    service();
    wait_valid(50);
    pulse_mask(8'h0F);
    base = bus_q.size();
    ready_mode = 1;
    wait_quiet(100);
    m_mask = 8'h0F;
    check("mask_access_count", 64'(bus_q.size() - base), 64'd1);
    if (bus_q.size() > base) begin
      check("mask_write", 64'(bus_q[base]), 64'({1'b1, 2'd2, 32'h0F}));
      check("mask_write_cycle", 64'(bus_cyc_q[base] - hs_cyc), 64'd2);
    end
    base = bus_q.size();
    toggle(8'h80);
    service();
    repeat (30) @(negedge clk);
    check("masked_no_bus", 64'(bus_q.size() - base), 64'd0);
    check("masked_no_event", 64'(evt_valid), 64'd0);

    // --- Spurious interrupts -------------------------------------------------
    base       = bus_q.size();
    rd3_base   = rd3_cnt;
    force_zero = 1'b1;
    fake_irq   = 1'b1;
    n_spur     = 1;
    for (int n = 0; n < 200 && rd3_cnt < rd3_base + n_spur; n++) @(negedge clk);
    fake_irq = 1'b0;
    wait_quiet(50);
    check("spurious_one", 64'(spurious_cnt), 64'd1);
    check("spurious_no_write", 64'(count_writes(base)), 64'd0);
    fake_irq = 1'b1;
    n_spur   = 300;
    for (int n = 0; n < 2000 && rd3_cnt < rd3_base + n_spur; n++) @(negedge clk);
    fake_irq = 1'b0;
    wait_quiet(50);
    check("spurious_reads", 64'(rd3_cnt - rd3_base), 64'(n_spur));
    check("spurious_sat", 64'(spurious_cnt), 64'((n_spur > 255) ? 255 : n_spur));
    check("spurious_no_write_all", 64'(count_writes(base)), 64'd0);
    force_zero = 1'b0;

    // --- Restore full mask, then randomized toggles --------------------------
    ready_mode = 2;
    m_mask     = 8'hFF;
    service();
    pulse_mask(8'hFF);
    wait_quiet(200);
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      toggle(8'($urandom_range(1, 255)));
      service();
      wait_quiet(400);
    end

    // --- Reset while a record waits in EMIT: record discarded ----------------
    ready_mode = 0;
    repeat (2) @(negedge clk);
    toggle(8'h10);
    service();
    wait_valid(50);
    reset = 1'b1;
    exp_q.delete();
    m_seq = 8'h00;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    @(negedge clk);
    base  = bus_q.size();
    reset = 1'b0;
    ready_mode = 1;
    wait_quiet(100);
    check("rst_emit_access_count", 64'(bus_q.size() - base), 64'd1);
    if (bus_q.size() > base)
      check("rst_emit_mask_write", 64'(bus_q[base]), 64'({1'b1, 2'd2, 32'hFF}));

    // --- Reset during RD_CAP: edge stays captured, serviced after init -------
    toggle(8'h02);
    wait_access(1'b0, 2'd3, 50);
    reset = 1'b1;
    m_seq = 8'h00;
    repeat (2) @(negedge clk);
    base  = bus_q.size();
    reset = 1'b0;
    service();
    wait_quiet(100);
    check("rst_cap_access_count", 64'(bus_q.size() - base), 64'd4);
    if (bus_q.size() >= base + 4) begin
      check("rst_cap_mask_write", 64'(bus_q[base]), 64'({1'b1, 2'd2, 32'hFF}));
      check("rst_cap_clr", 64'(bus_q[base + 2]), 64'({1'b1, 2'd3, 32'h02}));
    end
    check("rst_cap_spurious", 64'(spurious_cnt), 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
